fetch_prefetch_buffer: RTL and testbench
========================================

Name: fetch_prefetch_buffer

Overview:
- Next-generation instruction fetch front end. Decouples instruction-memory reads from decode with a parametrised halfword-granular prefetch FIFO.
- Handles mixed 16/32-bit (RVC) instruction streams, including 32-bit instructions that straddle a word boundary.
- Sits between the instruction RAM port and the IF/ID register. Redirects for branch, jal, jalr and trap arrive as a single redirect request.

Parameters:
- XLEN, 32, width of addresses and instruction output.
- DEPTH, 4, buffer capacity in 32-bit words (2*DEPTH halfword slots); power of two, ≥2.
- RESET_PC, 32'h0000_0000, fetch address after reset (word aligned).

Ports:
- clk  in  1  system clock
- Rst  in  1  synchronous active-high reset
- redirect  in  1  flush and restart fetch at redirect_addr
- redirect_addr  in  XLEN  target; bit 1 selects start halfword; bit 0 ignored
- imem_hold  in  1  memory busy; no new request may issue
- imem_en  out  1  read request this cycle
- imem_addr  out  XLEN  word-aligned read address (bits[1:0]=0)
- imem_dout  in  32  read data, valid exactly one cycle after an accepted request
- id_ready  in  1  decode accepts ins this cycle
- ins_valid  out  1  ins/ins_pc/comp_sig hold a complete instruction
- ins  out  XLEN  instruction; 16-bit parcels zero-extended to {16'h0, parcel}
- ins_pc  out  XLEN  address of the instruction's first halfword
- comp_sig  out  1  ins is a 16-bit instruction
- buf_level  out  $clog2(2*DEPTH)+1  valid halfwords in buffer

Behaviour:
- Reset (clk edge with Rst=1):
  - buffer empty; buf_level=0; ins_valid=0; ins=0; ins_pc=RESET_PC; comp_sig=0.
  - fetch_addr=RESET_PC; skip_hw=0; in-flight flag cleared; imem_en=0 while Rst=1.
  - Reset mid-operation discards any in-flight response.
- Request issue (combinational):
  - imem_en = !Rst && !redirect && !imem_hold && (buf_level + 2*inflight ≤ 2*DEPTH−2).
  - imem_addr = fetch_addr.
  - On an accepted request, fetch_addr += 4 and inflight is set for the next cycle.
- Response: in the cycle after an accepted request, imem_dout is written into the buffer (low halfword first) unless a flush occurred in between. If skip_hw=1, the low halfword is dropped, skip_hw clears, and only 1 halfword is written.
- Head decode, from the registered buffer only (no bypass from imem_dout):
  - head halfword h0: h0[1:0]≠2'b11 means 16-bit (includes h0=16'h0000, which is passed through for decode to flag illegal).
  - Otherwise 32-bit: requires 2 buffered halfwords; ins={h1,h0}.
  - ins_valid=1 only when the required halfwords are present.
- Consume: when ins_valid && id_ready && !redirect:
  - pop 1 or 2 halfwords; ins_pc advances by 2 or 4.
  - the same-cycle push (response) and pop are both applied; buf_level = old + pushed − popped.
- Redirect (cycle N):
  - buffer emptied and in-flight response discarded.
  - fetch_addr={redirect_addr[XLEN-1:2],2'b00}; skip_hw=redirect_addr[1]; ins_pc={redirect_addr[XLEN-1:1],1'b0}.
  - imem_en=0 in N.
  - First request in N+1 (if no hold), data written at end of N+2, ins_valid at N+3 (16-bit target or aligned 32-bit).
  - A 32-bit target at halfword offset 2 needs a second word: ins_valid at N+4 minimum.
  - Redirect overrides consume and Rst overrides redirect.
- Hold: imem_hold suppresses new requests only. A response for a request accepted the previous cycle still arrives and is written.
- Throughput: with id_ready=1 and no hold, sustains 1 instruction/cycle for 32-bit code and for 16-bit code (buffer refills 2 halfwords/cycle).
- Full: no request when it could overflow; buf_level never exceeds 2*DEPTH.
- Wrap-around: internal read/write pointers are modulo 2*DEPTH. fetch_addr wraps modulo 2^XLEN without error.
- Outputs are stable while ins_valid=1 and id_ready=0.

Test Plan:
- Reset, then release with memory returning 32'h00000013 at every word: imem_en with imem_addr 0 at cycle 1. ins_valid at cycle 3 with ins=32'h00000013, ins_pc=0, comp_sig=0. ins_pc steps 0,4,8 on successive cycles with id_ready=1.
- Word 0 = 32'h0001_4501 (two 16-bit parcels) and word 4 = 32'h00000013: ins 16'h4501@0 then 16'h0001@2, each comp_sig=1 and zero-extended, then 32'h00000013@4.
- Straddling case, word 0 = 32'h0093_4501, word 4 = 32'hXXXX_0000: 16'h4501@0, then 32-bit ins 32'h0000_0093@2 (h1 from word 4 low half), comp_sig=0, ins_valid not before word 4 arrives.
- Hold id_ready=0 for 20 cycles: buf_level saturates at 2*DEPTH (8), imem_en stays 0 once full, and ins is stable. Releasing id_ready drains in order with no lost or duplicated halfwords.
- Redirect to 32'h0000_0102 while a response is in flight: stale data is not delivered. imem_addr=32'h100 at N+1, ins_pc=32'h102 on first ins_valid, low halfword of word 32'h100 dropped.
- Assert imem_hold the cycle after a request: that response is still buffered, no new imem_en until hold drops, and Rst asserted mid-stream gives ins_valid=0 and buf_level=0 on the next edge.

Source files
------------

// File: rtl/fetch_prefetch_buffer_if.sv
// Bundle between the fetch buffer, the instruction RAM port, the redirect source and decode.
// master is the fetch buffer side; slave is the surrounding pipeline and memory.
interface fetch_prefetch_buffer_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LvlW = $clog2(2 * DEPTH) + 1;

  logic            redirect;
  logic [XLEN-1:0] redirect_addr;
  logic            imem_hold;
  logic            imem_en;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_dout;
  logic            id_ready;
  logic            ins_valid;
  logic [XLEN-1:0] ins;
  logic [XLEN-1:0] ins_pc;
  logic            comp_sig;
  logic [LvlW-1:0] buf_level;

  modport master (
    input  redirect, redirect_addr, imem_hold, imem_dout, id_ready,
    output imem_en, imem_addr, ins_valid, ins, ins_pc, comp_sig, buf_level
  );

  modport slave (
    output redirect, redirect_addr, imem_hold, imem_dout, id_ready,
    input  imem_en, imem_addr, ins_valid, ins, ins_pc, comp_sig, buf_level
  );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// Instruction fetch front end: word reads into a halfword FIFO, decoded into 16/32-bit
// instructions for the IF/ID register, with flush-and-restart on redirect.
module fetch_prefetch_buffer #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                     clk,
  input logic                     Rst,
  fetch_prefetch_buffer_if.master bus
);
  localparam int unsigned Slots = 2 * DEPTH;
  localparam int unsigned PtrW  = $clog2(Slots);
  localparam int unsigned LvlW  = PtrW + 1;
  localparam int unsigned DemW  = LvlW + 1;

  logic [15:0]     mem_q [Slots];
  logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic [XLEN-1:0] ins_pc_q, ins_pc_d;
  logic            skip_q, skip_d;
  logic            inflight_q, inflight_d;

  logic [15:0]     h0, h1;
  logic            is32, head_ok, consume, push_en;
  logic [LvlW-1:0] n_push, n_pop;
  logic [DemW-1:0] demand;
  logic            unused_addr_bit;

  assign unused_addr_bit = bus.redirect_addr[0];

  assign h0      = mem_q[rptr_q];
  assign h1      = mem_q[rptr_q + PtrW'(1)];
  assign is32    = (h0[1:0] == 2'b11);
  assign head_ok = is32 ? (level_q >= LvlW'(2)) : (level_q != '0);

  // Count the in-flight word as already occupying two slots so a response never overflows.
  assign demand       = {1'b0, level_q} + (inflight_q ? DemW'(2) : DemW'(0));
  assign bus.imem_en  = !Rst && !bus.redirect && !bus.imem_hold && (demand <= DemW'(Slots - 2));
  assign bus.imem_addr = fetch_addr_q;

  assign consume = head_ok && bus.id_ready && !bus.redirect;
  assign push_en = inflight_q && !bus.redirect;
  assign n_push  = push_en ? (skip_q ? LvlW'(1) : LvlW'(2)) : '0;
  assign n_pop   = consume ? (is32 ? LvlW'(2) : LvlW'(1)) : '0;

  always_comb begin
    rptr_d       = rptr_q + PtrW'(n_pop);
    wptr_d       = wptr_q + PtrW'(n_push);
    level_d      = level_q + n_push - n_pop;
    fetch_addr_d = bus.imem_en ? fetch_addr_q + XLEN'(4) : fetch_addr_q;
    ins_pc_d     = consume ? ins_pc_q + (is32 ? XLEN'(4) : XLEN'(2)) : ins_pc_q;
    skip_d       = push_en ? 1'b0 : skip_q;
    inflight_d   = bus.imem_en;
    if (bus.redirect) begin
      rptr_d       = '0;
      wptr_d       = '0;
      level_d      = '0;
      fetch_addr_d = {bus.redirect_addr[XLEN-1:2], 2'b00};
      ins_pc_d     = {bus.redirect_addr[XLEN-1:1], 1'b0};
      skip_d       = bus.redirect_addr[1];
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      rptr_q       <= '0;
      wptr_q       <= '0;
      level_q      <= '0;
      fetch_addr_q <= RESET_PC;
      ins_pc_q     <= RESET_PC;
      skip_q       <= 1'b0;
      inflight_q   <= 1'b0;
    end else begin
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      level_q      <= level_d;
      fetch_addr_q <= fetch_addr_d;
      ins_pc_q     <= ins_pc_d;
      skip_q       <= skip_d;
      inflight_q   <= inflight_d;
    end
  end

  // Storage needs no reset; level_q gates every read.
  always_ff @(posedge clk) begin
    if (!Rst && push_en) begin
      if (skip_q) begin
        mem_q[wptr_q] <= bus.imem_dout[31:16];
      end else begin
        mem_q[wptr_q]              <= bus.imem_dout[15:0];
        mem_q[wptr_q + PtrW'(1)]   <= bus.imem_dout[31:16];
      end
    end
  end

  assign bus.ins_valid = head_ok;
  assign bus.ins       = !head_ok ? '0 : (is32 ? XLEN'({h1, h0}) : XLEN'(h0));
  assign bus.comp_sig  = head_ok && !is32;
  assign bus.ins_pc    = ins_pc_q;
  assign bus.buf_level = level_q;
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: directed timing scenarios plus randomized traffic, with an
// ISA-level stream model (walk memory by pc, 16/32-bit by the low two bits) scoring every issue.
module tb_fetch_prefetch_buffer;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic Rst;
  always #5 clk = ~clk;

  fetch_prefetch_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_prefetch_buffer #(
    .XLEN(XLEN),
    .DEPTH(DEPTH),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .Rst(Rst),
    .bus(bus)
  );

  logic [31:0] imem [256];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_consumed = 0;

  logic [31:0] exp_pc;
  logic        prev_stall;
  logic [31:0] prev_ins, prev_pc;
  logic        prev_comp;
  logic [15:0] sb_h0;
  logic [31:0] sb_ins;
  logic        sb_comp;

  function automatic logic [15:0] ref_hw(input logic [31:0] a);
    logic [31:0] w;
    w = imem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Memory: data for an accepted request appears the following cycle, garbage otherwise.
  always @(posedge clk) bus.imem_dout <= bus.imem_en ? imem[bus.imem_addr[9:2]] : $urandom;

  // Stream scoreboard: every consumed instruction must be the next one of the program.
  always @(negedge clk) begin
    if (Rst) begin
      exp_pc     = 32'h0;
      prev_stall = 1'b0;
    end else begin
      n_cmp++;
      if (bus.buf_level > 4'd8) begin
        n_fail++;
        $display("FAIL buf_level_bound: got %0d, want <= 8", bus.buf_level);
      end
      if (prev_stall) begin
        n_cmp++;
        if (bus.ins_valid !== 1'b1 || bus.ins !== prev_ins || bus.ins_pc !== prev_pc ||
            bus.comp_sig !== prev_comp) begin
          n_fail++;
          $display("FAIL stall_stable: got v=%b ins=%h pc=%h c=%b, want v=1 ins=%h pc=%h c=%b",
                   bus.ins_valid, bus.ins, bus.ins_pc, bus.comp_sig, prev_ins, prev_pc, prev_comp);
        end
      end
      if (bus.redirect) begin
        exp_pc = {bus.redirect_addr[31:1], 1'b0};
      end else if (bus.ins_valid && bus.id_ready) begin
        sb_h0 = ref_hw(exp_pc);
        if (sb_h0[1:0] == 2'b11) begin
          sb_ins  = {ref_hw(exp_pc + 32'd2), sb_h0};
          sb_comp = 1'b0;
        end else begin
          sb_ins  = {16'h0, sb_h0};
          sb_comp = 1'b1;
        end
        n_cmp++;
        if (bus.ins !== sb_ins || bus.ins_pc !== exp_pc || bus.comp_sig !== sb_comp) begin
          n_fail++;
          $display("FAIL stream: got ins=%h pc=%h c=%b, want ins=%h pc=%h c=%b",
                   bus.ins, bus.ins_pc, bus.comp_sig, sb_ins, exp_pc, sb_comp);
        end
        exp_pc = exp_pc + (sb_comp ? 32'd2 : 32'd4);
        n_consumed++;
      end
      prev_stall = bus.ins_valid && !bus.id_ready && !bus.redirect;
      prev_ins   = bus.ins;
      prev_pc    = bus.ins_pc;
      prev_comp  = bus.comp_sig;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int i = 0; i < 256; i++) imem[i] = v;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
  endtask

  task automatic idle_inputs();
    bus.redirect      = 1'b0;
    bus.redirect_addr = 32'h0;
    bus.imem_hold     = 1'b0;
    bus.id_ready      = 1'b0;
  endtask

  // Leaves the bench at the start of cycle 1 (first cycle with Rst low).
  task automatic reset_dut();
    Rst = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    fill_const(32'h0000_0013);
    Rst = 1'b1;
    idle_inputs();
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.imem_en !== 1'b0 || bus.ins_valid !== 1'b0 || bus.buf_level !== 4'd0 ||
        bus.ins !== 32'h0 || bus.ins_pc !== 32'h0 || bus.comp_sig !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got en=%b v=%b lvl=%0d ins=%h pc=%h c=%b, want all zero",
               bus.imem_en, bus.ins_valid, bus.buf_level, bus.ins, bus.ins_pc, bus.comp_sig);
    end
    next_cycle();
    Rst = 1'b0;
    bus.id_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.imem_en !== 1'b1 || bus.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_first_req: got en=%b addr=%h, want en=1 addr=0",
               bus.imem_en, bus.imem_addr);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.ins_valid !== 1'b0 || bus.imem_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL reset_cycle2: got v=%b addr=%h, want v=0 addr=4", bus.ins_valid, bus.imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if (bus.ins_valid !== 1'b1 || bus.ins !== 32'h13 || bus.ins_pc !== 32'(4 * k) ||
          bus.comp_sig !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_stream[%0d]: got v=%b ins=%h pc=%h c=%b, want v=1 ins=13 pc=%h c=0",
                 k, bus.ins_valid, bus.ins, bus.ins_pc, bus.comp_sig, 32'(4 * k));
      end
    end
  endtask

  task automatic test_rvc_mix();
    logic [31:0] e_ins  [3];
    logic [31:0] e_pc   [3];
    logic        e_comp [3];
    int          got;
    e_ins  = '{32'h0000_4501, 32'h0000_0001, 32'h0000_0013};
    e_pc   = '{32'h0, 32'h2, 32'h4};
    e_comp = '{1'b1, 1'b1, 1'b0};
    fill_const(32'h0000_0013);
    imem[0] = 32'h0001_4501;
    reset_dut();
    bus.id_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk);
      if (bus.ins_valid) begin
        n_cmp++;
        if (bus.ins !== e_ins[got] || bus.ins_pc !== e_pc[got] || bus.comp_sig !== e_comp[got]) begin
          n_fail++;
          $display("FAIL rvc_mix[%0d]: got ins=%h pc=%h c=%b, want ins=%h pc=%h c=%b", got,
                   bus.ins, bus.ins_pc, bus.comp_sig, e_ins[got], e_pc[got], e_comp[got]);
        end
        got++;
      end
      next_cycle();
    end
    n_cmp++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL rvc_mix_timeout: got %0d instructions, want 3", got);
    end
  endtask

  task automatic test_straddle();
    fill_const(32'h0000_0013);
    imem[0] = 32'h0093_4501;
    imem[1] = 32'h0001_0000;
    reset_dut();
    bus.id_ready = 1'b1;
    @(negedge clk);
    next_cycle();
    bus.imem_hold = 1'b1;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.ins_valid !== 1'b1 || bus.ins !== 32'h4501 || bus.ins_pc !== 32'h0 ||
        bus.comp_sig !== 1'b1) begin
      n_fail++;
      $display("FAIL straddle_first: got v=%b ins=%h pc=%h c=%b, want v=1 ins=4501 pc=0 c=1",
               bus.ins_valid, bus.ins, bus.ins_pc, bus.comp_sig);
    end
    next_cycle();
    for (int c = 4; c <= 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.ins_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL straddle_early[%0d]: got v=%b ins=%h, want v=0", c, bus.ins_valid, bus.ins);
      end
      next_cycle();
      if (c == 4) bus.imem_hold = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (bus.ins_valid !== 1'b1 || bus.ins !== 32'h0000_0093 || bus.ins_pc !== 32'h2 ||
        bus.comp_sig !== 1'b0) begin
      n_fail++;
      $display("FAIL straddle_32: got v=%b ins=%h pc=%h c=%b, want v=1 ins=00000093 pc=2 c=0",
               bus.ins_valid, bus.ins, bus.ins_pc, bus.comp_sig);
    end
  endtask

  task automatic test_full();
    logic        seen_full;
    logic        got_first;
    logic [31:0] first_ins;
    int          c0;
    fill_random();
    reset_dut();
    seen_full = 1'b0;
    got_first = 1'b0;
    first_ins = 32'h0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.buf_level == 4'd8) seen_full = 1'b1;
      if (seen_full) begin
        n_cmp++;
        if (bus.imem_en !== 1'b0) begin
          n_fail++;
          $display("FAIL full_no_req[%0d]: got en=%b lvl=%0d, want en=0", c, bus.imem_en,
                   bus.buf_level);
        end
      end
      if (bus.ins_valid && !got_first) begin
        got_first = 1'b1;
        first_ins = bus.ins;
      end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++;
    if (bus.buf_level !== 4'd8 || bus.ins_valid !== 1'b1 || bus.ins !== first_ins) begin
      n_fail++;
      $display("FAIL full_saturate: got lvl=%0d v=%b ins=%h, want lvl=8 v=1 ins=%h",
               bus.buf_level, bus.ins_valid, bus.ins, first_ins);
    end
    next_cycle();
    bus.id_ready = 1'b1;
    c0 = n_consumed;
    repeat (40) next_cycle();
    n_cmp++;
    if (n_consumed - c0 < 30) begin
      n_fail++;
      $display("FAIL full_drain: got %0d instructions in 40 cycles, want >= 30", n_consumed - c0);
    end
  endtask

  task automatic test_redirect();
    fill_const(32'h0000_0013);
    imem[32'h100 >> 2] = 32'h4501_1234;
    imem[32'h200 >> 2] = 32'h0013_5555;
    imem[32'h204 >> 2] = 32'h0001_0000;
    reset_dut();
    bus.id_ready = 1'b1;
    repeat (5) next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.imem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL redir_pre_req: got en=%b, want en=1", bus.imem_en);
    end
    next_cycle();
    bus.redirect      = 1'b1;
    bus.redirect_addr = 32'h0000_0102;
    @(negedge clk);
    n_cmp++;
    if (bus.imem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_n_en: got en=%b, want en=0", bus.imem_en);
    end
    next_cycle();
    bus.redirect = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.imem_en !== 1'b1 || bus.imem_addr !== 32'h100 || bus.ins_valid !== 1'b0 ||
        bus.buf_level !== 4'd0) begin
      n_fail++;
      $display("FAIL redir_n1: got en=%b addr=%h v=%b lvl=%0d, want en=1 addr=100 v=0 lvl=0",
               bus.imem_en, bus.imem_addr, bus.ins_valid, bus.buf_level);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.ins_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_n2_stale: got v=%b ins=%h, want v=0", bus.ins_valid, bus.ins);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h102 || bus.ins !== 32'h4501 ||
        bus.comp_sig !== 1'b1) begin
      n_fail++;
      $display("FAIL redir_n3: got v=%b ins=%h pc=%h c=%b, want v=1 ins=4501 pc=102 c=1",
               bus.ins_valid, bus.ins, bus.ins_pc, bus.comp_sig);
    end
    next_cycle();
    bus.redirect      = 1'b1;
    bus.redirect_addr = 32'h0000_0202;
    @(negedge clk);
    next_cycle();
    bus.redirect = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.imem_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL redir2_addr: got addr=%h, want addr=200", bus.imem_addr);
    end
    next_cycle();
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.ins_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir2_n3_early: got v=%b ins=%h, want v=0", bus.ins_valid, bus.ins);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h202 || bus.ins !== 32'h0000_0013 ||
        bus.comp_sig !== 1'b0) begin
      n_fail++;
      $display("FAIL redir2_n4: got v=%b ins=%h pc=%h c=%b, want v=1 ins=00000013 pc=202 c=0",
               bus.ins_valid, bus.ins, bus.ins_pc, bus.comp_sig);
    end
  endtask

  task automatic test_hold_reset();
    fill_const(32'h0000_0013);
    reset_dut();
    @(negedge clk);
    n_cmp++;
    if (bus.imem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_first_req: got en=%b, want en=1", bus.imem_en);
    end
    next_cycle();
    bus.imem_hold = 1'b1;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.imem_en !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_no_req[%0d]: got en=%b, want en=0", c, bus.imem_en);
      end
      if (c == 3) begin
        n_cmp++;
        if (bus.buf_level !== 4'd2) begin
          n_fail++;
          $display("FAIL hold_resp_kept: got lvl=%0d, want lvl=2", bus.buf_level);
        end
      end
      next_cycle();
    end
    bus.imem_hold = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.imem_en !== 1'b1 || bus.imem_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL hold_release: got en=%b addr=%h, want en=1 addr=4", bus.imem_en,
               bus.imem_addr);
    end
    next_cycle();
    bus.id_ready = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.ins_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_stream_live: got v=%b, want v=1", bus.ins_valid);
    end
    next_cycle();
    Rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.imem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_en: got en=%b, want en=0", bus.imem_en);
    end
    next_cycle();
    Rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.ins_valid !== 1'b0 || bus.buf_level !== 4'd0 || bus.ins_pc !== 32'h0 ||
        bus.ins !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_state: got v=%b lvl=%0d pc=%h ins=%h, want v=0 lvl=0 pc=0 ins=0",
               bus.ins_valid, bus.buf_level, bus.ins_pc, bus.ins);
    end
  endtask

  task automatic test_random();
    int c0;
    int r;
    for (int round = 0; round < 4; round++) begin
      fill_random();
      reset_dut();
      c0 = n_consumed;
      for (int c = 0; c < 300; c++) begin
        r = int'($urandom_range(0, 99));
        bus.id_ready      = ($urandom_range(0, 9) < 7);
        bus.imem_hold     = ($urandom_range(0, 9) < 2);
        bus.redirect      = (r < 3);
        bus.redirect_addr = (r == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 1023));
        Rst               = (r == 99 && c > 10);
        next_cycle();
      end
      idle_inputs();
      Rst = 1'b0;
      n_cmp++;
      if (n_consumed - c0 < 50) begin
        n_fail++;
        $display("FAIL random_progress[%0d]: got %0d instructions, want >= 50", round,
                 n_consumed - c0);
      end
    end
  endtask

  initial begin
    Rst = 1'b1;
    idle_inputs();
    test_reset();
    test_rvc_mix();
    test_straddle();
    test_full();
    test_redirect();
    test_hold_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test by 1000000, want earlier finish");
    $fatal(1);
  end
endmodule
